// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and ALU opcodes for the sequential multiply/divide unit
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] MUL = 5'b00110;
    localparam logic [4:0] DIV = 5'b00111;

endpackage

// File: rtl/multdiv_addsub.sv
// rtl/multdiv_addsub.sv - add/subtract step shared by the shift-add multiply and restoring divide
module multdiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - sequential signed multiply/divide, fixed WIDTH+1 cycle latency; MULTDIV_REMAINDER_EN adds data_remainder
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [4:0]       op_q;
    logic             sign_a, sign_b, div_zero, div_ovf;
    // mult: hi = partial product, lo = multiplier; div: hi = remainder, lo = dividend/quotient
    logic [WIDTH-1:0] hi, lo, mag_b;

    logic             start;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   as_a, as_b, as_y;
    logic             as_sub;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH:0]   prod_top;
    logic             mul_exc;
    logic [WIDTH-1:0] quot, rem;

    assign start = ctrl_MULT | ctrl_DIV;

    always_comb begin
        mag_a_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        mag_b_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    end

    always_comb begin
        as_b = {1'b0, mag_b};
        if (op_q == MUL) begin
            as_a   = {1'b0, hi};
            as_sub = 1'b0;
        end else begin
            as_a   = {hi, lo[WIDTH-1]};
            as_sub = 1'b1;
        end
    end

    multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (op_q == MUL) begin
            if (lo[0]) {hi_n, lo_n} = {as_y, lo[WIDTH-1:1]};
            else       {hi_n, lo_n} = {1'b0, hi, lo[WIDTH-1:1]};
        end else begin
            // a clear top bit means the trial subtraction did not borrow
            if (!as_y[WIDTH]) begin
                hi_n = as_y[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = as_a[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_mag = {hi, lo};
        prod     = (sign_a ^ sign_b) ? (~prod_mag + 1'b1) : prod_mag;
        prod_top = prod[2*WIDTH-1:WIDTH-1];
        mul_exc  = !((&prod_top) || !(|prod_top));
        quot     = (sign_a ^ sign_b) ? (~lo + 1'b1) : lo;
        rem      = sign_a ? (~hi + 1'b1) : hi;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            op_q           <= MUL;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            hi             <= '0;
            lo             <= '0;
            mag_b          <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else if (start) begin
            // a start in any state restarts; an aborted op never reaches DONE
            state          <= RUN;
            cnt            <= '0;
            op_q           <= ctrl_MULT ? MUL : DIV;
            sign_a         <= data_operandA[WIDTH-1];
            sign_b         <= data_operandB[WIDTH-1];
            div_zero       <= (data_operandB == '0);
            div_ovf        <= (data_operandA == MIN_VAL) && (data_operandB == '1);
            hi             <= '0;
            lo             <= ctrl_MULT ? mag_b_in : mag_a_in;
            mag_b          <= ctrl_MULT ? mag_a_in : mag_b_in;
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cnt == CW'(WIDTH)) begin
                        state          <= DONE;
                        data_resultRDY <= 1'b1;
                        if (op_q == MUL) begin
                            data_result    <= prod[WIDTH-1:0];
                            data_exception <= mul_exc;
                        end else if (div_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= quot;
                            data_exception <= div_ovf;
                        end
`ifdef MULTDIV_REMAINDER_EN
                        data_remainder <= ((op_q == MUL) || div_zero) ? '0 : rem;
`endif
                    end else begin
                        hi  <= hi_n;
                        lo  <= lo_n;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Port: clock, in, 1, master clock; all state updates on rising edge.
REQ-003 Port: reset, in, 1, asynchronous, active-low reset.
REQ-004 Port: data_operandA, in, WIDTH, multiplicand/dividend (two's complement).
REQ-005 Port: data_operandB, in, WIDTH, multiplier/divisor (two's complement).
REQ-006 Port: ctrl_MULT, in, 1, single-cycle start pulse for multiply.
REQ-007 Port: ctrl_DIV, in, 1, single-cycle start pulse for divide.
REQ-008 Port: data_result, out, WIDTH, product low bits or quotient.
REQ-009 Port: data_exception, out, 1, overflow or divide-by-zero flag; valid with result.
REQ-010 Port: data_resultRDY, out, 1, one-cycle completion pulse.
REQ-011 Port: busy, out, 1, high while an operation is in flight; drives the pipeline stall.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after WIDTH iteration cycles.
- DONE->IDLE after one cycle.
REQ-013 A start is a rising edge with ctrl_MULT or ctrl_DIV high; operands, op and operand signs SHALL be captured at that edge.
REQ-014 If ctrl_MULT and ctrl_DIV are both high, multiply SHALL take priority.
REQ-015 Multiply SHALL use radix-2 shift-add on operand magnitudes, then negate the product when the signs differ.
REQ-016 Divide SHALL use restoring division on magnitudes.
- Quotient truncates toward zero.
- Remainder takes the dividend's sign.
REQ-017 Latency SHALL be fixed for every op, including divide-by-zero. If the start is at edge E0, data_resultRDY SHALL be high exactly in the cycle following edge E(WIDTH+1).
REQ-018 data_result and data_exception SHALL update only on entry to DONE and hold until the next DONE.
REQ-019 Multiply exception SHALL be 1 when the full 2*WIDTH signed product does not fit in WIDTH bits; data_result SHALL still be the low WIDTH bits.
REQ-020 Divide by zero SHALL give data_result=0 and data_exception=1.
REQ-021 Divide of MIN by -1 SHALL give data_result=MIN and data_exception=1.
REQ-022 busy SHALL be high from the cycle after the start edge through the DONE cycle inclusive.
REQ-023 A start received in RUN or DONE SHALL abort the current op and restart with the new operands. The aborted op SHALL produce no data_resultRDY pulse.

Reset
REQ-024 Asserting reset SHALL immediately force:
- state IDLE;
- busy=0, data_resultRDY=0, data_result=0, data_exception=0;
- iteration counter 0.
REQ-025 Reset asserted mid-operation SHALL discard the op; no data_resultRDY SHALL follow deassertion.
REQ-026 A start pulse coincident with the reset deassertion edge SHALL be honoured.

Configuration
REQ-027 Macro MULTDIV_REMAINDER_EN, when defined:
- adds output port data_remainder, width WIDTH, with the REQ-016 remainder sign rule;
- data_remainder is 0 after multiply, 0 on divide-by-zero, and 0 on reset.
REQ-028 When MULTDIV_REMAINDER_EN is undefined, port data_remainder and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Shared package multdiv_pkg SHALL hold:
- the state enumeration (IDLE, RUN, DONE);
- ALU opcode constants MUL=5'b00110 and DIV=5'b00111.
REQ-030 The (WIDTH+1)-bit add/subtract step datapath SHALL be a sub-module named multdiv_addsub; the iteration counter SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=32)
REQ-031 MULT, A=7, B=-3 -> RDY one cycle after edge E33, result 0xFFFFFFEB, exception 0.
REQ-032 MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1.
REQ-033 DIV, A=-20, B=6 -> result 0xFFFFFFFD, exception 0; with MULTDIV_REMAINDER_EN, remainder 0xFFFFFFFE.
REQ-034 DIV, A=5, B=0 -> RDY at the same latency, result 0, exception 1. DIV, A=0x80000000, B=-1 -> result 0x80000000, exception 1.
REQ-035 Abort: MULT 3*4 started, then DIV 100/7 started 10 cycles later -> a single RDY pulse 33 cycles after the second start, result 14; no pulse for the multiply.
REQ-036 Reset asserted during the 20th RUN cycle -> outputs 0 immediately, no RDY afterwards. MULT and DIV pulsed together with A=6, B=2 -> result 12.
